// File: rtl/max_done_tracker.sv
// Tracks a shrinking candidate mask until one channel (or none) survives.
// Optional iteration limit is compiled in with macro DONE_TIMEOUT_EN.
module max_done_tracker #(
   parameter int N        = 4,
   parameter int IDX_W    = 2,
   parameter int MAX_ITER = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mask_valid,
   input  logic [N-1:0]     mask,
   input  logic             ack,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] winner_idx,
   output logic             none_flag,
   output logic [7:0]       iter_count,
   output logic             timeout
);

   // state | meaning
   // IDLE  | waiting for start
   // RUN   | consuming masks until 0/1 survivors (or limit)
   // DONE  | result held until ack or a new start
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   if (N < 2 || IDX_W < 1 || (2 ** IDX_W) < N || MAX_ITER < 1 || MAX_ITER > 255) begin : g_param_check
      $error("max_done_tracker: illegal parameter set");
   end

   state_t           state;
   logic             mask_zero;
   logic             mask_one;
   logic [IDX_W-1:0] set_idx;
   logic [7:0]       iter_next;
   logic             hit_limit;

   // One-hot test via x & (x-1) so it does not depend on bit ordering.
   always_comb begin
      mask_zero = (mask == '0);
      mask_one  = !mask_zero && ((mask & (mask - N'(1))) == '0);
      set_idx   = '0;
      for (int i = 0; i < N; i++) begin
         if (mask[i]) set_idx = IDX_W'(i);
      end
      iter_next = (iter_count == 8'hFF) ? iter_count : iter_count + 8'd1;
`ifdef DONE_TIMEOUT_EN
      hit_limit = (iter_next == 8'(MAX_ITER));
`else
      hit_limit = 1'b0;
`endif
   end

`ifdef DONE_TIMEOUT_EN
   logic timeout_q;
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         winner_idx <= '0;
         none_flag  <= 1'b0;
         iter_count <= 8'd0;
`ifdef DONE_TIMEOUT_EN
         timeout_q  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= RUN;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  winner_idx <= '0;
                  none_flag  <= 1'b0;
                  iter_count <= 8'd0;
`ifdef DONE_TIMEOUT_EN
                  timeout_q  <= 1'b0;
`endif
               end else if (state == DONE && ack) begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
            end
            RUN: begin
               if (mask_valid) begin
                  iter_count <= iter_next;
                  if (mask_zero || mask_one || hit_limit) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
                  // Survivor conditions outrank the limit in the same cycle.
                  if (mask_zero) begin
                     none_flag  <= 1'b1;
                     winner_idx <= '0;
                  end else if (mask_one) begin
                     winner_idx <= set_idx;
                  end
`ifdef DONE_TIMEOUT_EN
                  else if (hit_limit) begin
                     timeout_q <= 1'b1;
                  end
`endif
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
